// File: rtl/nano_motor_ramp_pkg.sv
// nano_motor_ramp_pkg
//   Shared definitions for the Nano rover motor output stage: channel state
//   encodings, H-bridge pin-pair encodings, the duty-level width and small
//   helpers used by the per-channel ramp logic.
package nano_motor_ramp_pkg;

  localparam int NUM_CH = 2;
  localparam int LVL_W  = 3;
  localparam logic [LVL_W-1:0] LVL_MAX = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DECEL = 3'd2,
    ST_DEAD  = 3'd3,
    ST_BRAKE = 3'd4
  } state_e;

  // {IN1, IN2}
  localparam logic [1:0] PINS_COAST = 2'b00;
  localparam logic [1:0] PINS_FWD   = 2'b10;
  localparam logic [1:0] PINS_REV   = 2'b01;
  localparam logic [1:0] PINS_BRAKE = 2'b11;

  function automatic logic [1:0] dir_pins(input logic dir);
    return dir ? PINS_FWD : PINS_REV;
  endfunction

  // One level step from cur toward tgt (no change when equal).
  function automatic logic [LVL_W-1:0] step_toward(input logic [LVL_W-1:0] cur,
                                                   input logic [LVL_W-1:0] tgt);
    if (cur < tgt) return cur + 1'b1;
    if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

endpackage

// File: rtl/nano_motor_ramp_channel.sv
// nano_motor_ramp_channel
//   One motor channel: input synchronizers, IDLE/RUN/DECEL/DEAD/BRAKE FSM,
//   ramp/dead-time tick counter, duty level register and PWM compare.
//   Ports:
//     clk_i, rst_ni      clock, async active-low reset
//     speed_i, dir_i,    raw (unsynchronized) commands
//     brake_i
//     pwm_cnt_i, tick_i  shared period counter and its last-cycle strobe
//     step_i             cycles of on-time per duty level
//     en_o               registered bridge enable
//     in1_o, in2_o       registered bridge direction pins
//     busy_o             level still moving, or reversal in progress
module nano_motor_ramp_channel
  import nano_motor_ramp_pkg::*;
#(
  parameter int CW               = 5,
  parameter int RAMP_PERIODS     = 4,
  parameter int DEADTIME_PERIODS = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [LVL_W-1:0] speed_i,
  input  logic             dir_i,
  input  logic             brake_i,
  input  logic [CW-1:0]    pwm_cnt_i,
  input  logic             tick_i,
  input  logic [CW-1:0]    step_i,
  output logic             en_o,
  output logic             in1_o,
  output logic             in2_o,
  output logic             busy_o
);

  localparam int RD_MAX = (RAMP_PERIODS > DEADTIME_PERIODS) ? RAMP_PERIODS : DEADTIME_PERIODS;
  localparam int RCW    = $clog2(RD_MAX + 1);
  localparam logic [RCW-1:0] RAMP_LAST = RCW'(RAMP_PERIODS - 1);
  localparam logic [RCW-1:0] DEAD_LAST = RCW'(DEADTIME_PERIODS - 1);

  // 2-flop synchronizer: {speed, dir, brake}
  logic [LVL_W+1:0] sync1_q, sync2_q;
  logic [LVL_W-1:0] s_speed;
  logic             s_dir, s_brake;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {speed_i, dir_i, brake_i};
      sync2_q <= sync1_q;
    end
  end

  assign s_speed = sync2_q[LVL_W+1:2];
  assign s_dir   = sync2_q[1];
  assign s_brake = sync2_q[0];

  state_e           st_q;
  logic [LVL_W-1:0] level_q, tgt_q;
  logic             cur_dir_q;
  logic [RCW-1:0]   ramp_q;
  logic [1:0]       pins_q;
  logic             en_q;

  // Level 7 is full-on; a 7*STEP compare would leave a gap each period.
  logic [CW-1:0] thresh;
  logic          duty_on;
  assign thresh  = CW'(level_q) * step_i;
  assign duty_on = (level_q == LVL_MAX) || (pwm_cnt_i < thresh);

  // Brake is the only asynchronous-to-tick transition; everything else waits
  // for the period boundary so pins and duty never change mid-period.
  // ramp_q doubles as the dead-time counter while in DEAD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q      <= ST_IDLE;
      level_q   <= '0;
      tgt_q     <= '0;
      cur_dir_q <= 1'b0;
      ramp_q    <= '0;
      pins_q    <= PINS_COAST;
      en_q      <= 1'b0;
    end else begin
      en_q <= duty_on;
      if (s_brake) begin
        st_q    <= ST_BRAKE;
        level_q <= '0;
        tgt_q   <= '0;
        ramp_q  <= '0;
        pins_q  <= PINS_BRAKE;
        en_q    <= 1'b1;
      end else if (tick_i) begin
        case (st_q)
          ST_IDLE: begin
            if (s_speed != '0) begin
              st_q      <= ST_RUN;
              cur_dir_q <= s_dir;
              pins_q    <= dir_pins(s_dir);
              tgt_q     <= s_speed;
              ramp_q    <= '0;
            end
          end
          ST_RUN: begin
            if (s_dir != cur_dir_q) begin
              st_q   <= ST_DECEL;
              tgt_q  <= '0;
              ramp_q <= '0;
            end else if (level_q == '0 && s_speed == '0) begin
              st_q   <= ST_IDLE;
              pins_q <= PINS_COAST;
              tgt_q  <= '0;
              ramp_q <= '0;
            end else if (s_speed != tgt_q) begin
              // new target: restart the step interval
              tgt_q  <= s_speed;
              ramp_q <= '0;
            end else if (level_q == tgt_q) begin
              ramp_q <= '0;
            end else if (ramp_q == RAMP_LAST) begin
              ramp_q  <= '0;
              level_q <= step_toward(level_q, tgt_q);
            end else begin
              ramp_q <= ramp_q + 1'b1;
            end
          end
          ST_DECEL: begin
            if (level_q == '0 || (level_q == LVL_W'(1) && ramp_q == RAMP_LAST)) begin
              st_q    <= ST_DEAD;
              level_q <= '0;
              pins_q  <= PINS_COAST;
              ramp_q  <= '0;
            end else if (ramp_q == RAMP_LAST) begin
              ramp_q  <= '0;
              level_q <= level_q - 1'b1;
            end else begin
              ramp_q <= ramp_q + 1'b1;
            end
          end
          ST_DEAD: begin
            if (ramp_q == DEAD_LAST) begin
              st_q      <= ST_RUN;
              cur_dir_q <= s_dir;
              pins_q    <= dir_pins(s_dir);
              tgt_q     <= s_speed;
              ramp_q    <= '0;
            end else begin
              ramp_q <= ramp_q + 1'b1;
            end
          end
          ST_BRAKE: begin
            st_q   <= ST_IDLE;
            pins_q <= PINS_COAST;
          end
          default: st_q <= ST_IDLE;
        endcase
      end else if (st_q == ST_BRAKE) begin
        en_q <= 1'b1;
      end
    end
  end

  assign en_o   = en_q;
  assign in1_o  = pins_q[1];
  assign in2_o  = pins_q[0];
  assign busy_o = (st_q == ST_DECEL) || (st_q == ST_DEAD) ||
                  (((st_q == ST_RUN) || (st_q == ST_IDLE)) && (level_q != s_speed));

endmodule

// File: rtl/nano_motor_ramp.sv
// nano_motor_ramp
//   Two-channel ramped PWM motor output stage feeding an L298N-style bridge.
//   Holds the shared PWM period counter and two channel instances.
//   PERIOD = CLK_HZ/PWM_HZ must be at least 7.
//   Ports:
//     clock, reset              clock, async active-low reset
//     speed_a/b, dir_a/b,       per-channel commands (level 0..7, 1 = forward,
//     brake_a/b                 level-sensitive brake)
//     enableA/B                 registered PWM enables
//     JA1/JA2, JA3/JA4          registered IN1/IN2 for channel A / B
//     busy_a/b                  channel still ramping or reversing
module nano_motor_ramp
  import nano_motor_ramp_pkg::*;
#(
  parameter int CLK_HZ           = 100_000_000,
  parameter int PWM_HZ           = 1_000,
  parameter int RAMP_PERIODS     = 4,
  parameter int DEADTIME_PERIODS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] speed_a,
  input  logic [2:0] speed_b,
  input  logic       dir_a,
  input  logic       dir_b,
  input  logic       brake_a,
  input  logic       brake_b,
  output logic       enableA,
  output logic       enableB,
  output logic       JA1,
  output logic       JA2,
  output logic       JA3,
  output logic       JA4,
  output logic       busy_a,
  output logic       busy_b
);

  localparam int PERIOD = CLK_HZ / PWM_HZ;
  localparam int CW     = $clog2(PERIOD) + 1;
  localparam logic [CW-1:0] STEP      = CW'(PERIOD / 7);
  localparam logic [CW-1:0] PCNT_LAST = CW'(PERIOD - 1);

  logic [CW-1:0] pwm_cnt_q;
  logic          tick;

  assign tick = (pwm_cnt_q == PCNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    pwm_cnt_q <= '0;
    else if (tick) pwm_cnt_q <= '0;
    else           pwm_cnt_q <= pwm_cnt_q + 1'b1;
  end

  logic [NUM_CH-1:0][LVL_W-1:0] spd_v;
  logic [NUM_CH-1:0]            dir_v, brk_v, en_v, in1_v, in2_v, busy_v;

  assign spd_v = {speed_b, speed_a};
  assign dir_v = {dir_b, dir_a};
  assign brk_v = {brake_b, brake_a};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    nano_motor_ramp_channel #(
      .CW               (CW),
      .RAMP_PERIODS     (RAMP_PERIODS),
      .DEADTIME_PERIODS (DEADTIME_PERIODS)
    ) u_ch (
      .clk_i     (clock),
      .rst_ni    (reset),
      .speed_i   (spd_v[c]),
      .dir_i     (dir_v[c]),
      .brake_i   (brk_v[c]),
      .pwm_cnt_i (pwm_cnt_q),
      .tick_i    (tick),
      .step_i    (STEP),
      .en_o      (en_v[c]),
      .in1_o     (in1_v[c]),
      .in2_o     (in2_v[c]),
      .busy_o    (busy_v[c])
    );
  end

  assign enableA = en_v[0];
  assign enableB = en_v[1];
  assign JA1     = in1_v[0];
  assign JA2     = in2_v[0];
  assign JA3     = in1_v[1];
  assign JA4     = in2_v[1];
  assign busy_a  = busy_v[0];
  assign busy_b  = busy_v[1];

endmodule

// File: tb/tb_nano_motor_ramp.sv
// Directed bench for nano_motor_ramp with PERIOD=16, STEP=2, RAMP_PERIODS=2,
// DEADTIME_PERIODS=3. Observations are taken per PWM period: a window is the
// 16 negedge samples following the tick edge, in which a level L gives 2*L
// enable-high samples (16 at level 7).
module tb_nano_motor_ramp;

  logic       clock = 1'b0, reset = 1'b0;
  logic [2:0] speed_a = '0, speed_b = '0;
  logic       dir_a = 1'b0, dir_b = 1'b0, brake_a = 1'b0, brake_b = 1'b0;
  logic       enableA, enableB, JA1, JA2, JA3, JA4, busy_a, busy_b;

  int checks = 0;
  int passes = 0;
  int cyc;
  int hA, hB, live_flip;
  logic [1:0] pA, pB, prevA;
  logic stA, stB, bA, bB;

  int         ramp_hi   [8]  = '{0, 0, 0, 2, 2, 4, 4, 6};
  logic [1:0] ramp_pins [8]  = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  logic       ramp_busy [8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
  int         rev_hi    [17] = '{6, 6, 6, 4, 4, 2, 2, 0, 0, 0, 0, 0, 2, 2, 4, 4, 6};
  logic [1:0] rev_pins  [17] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                 2'b00, 2'b00, 2'b00,
                                 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
  logic       rev_busy  [17] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int         full_hi   [17] = '{0, 0, 0, 2, 2, 4, 4, 6, 6, 8, 8, 10, 10, 12, 12, 16, 16};
  int         brk_hi    [6]  = '{16, 15, 0, 0, 0, 2};
  logic [1:0] brk_pins  [6]  = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b10};
  int         rst_hi    [6]  = '{0, 0, 0, 2, 2, 4};
  logic [1:0] rstA_pins [6]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [1:0] rstB_pins [6]  = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};

  nano_motor_ramp #(
    .CLK_HZ(16000), .PWM_HZ(1000), .RAMP_PERIODS(2), .DEADTIME_PERIODS(3)
  ) dut (
    .clock(clock), .reset(reset),
    .speed_a(speed_a), .speed_b(speed_b),
    .dir_a(dir_a), .dir_b(dir_b),
    .brake_a(brake_a), .brake_b(brake_b),
    .enableA(enableA), .enableB(enableB),
    .JA1(JA1), .JA2(JA2), .JA3(JA3), .JA4(JA4),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  always #5 clock = ~clock;

  // edges since reset release; the PWM counter equals cyc % 16
  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout: bench stalled after %0d checks", checks);
    $fatal(1, "timeout");
  end

  task automatic align();
    while (cyc % 16 != 0) @(negedge clock);
  endtask

  task automatic measure();
    hA = 0; hB = 0; stA = 1'b1; stB = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (enableA) hA++;
      if (enableB) hB++;
      if (enableA && {JA1, JA2} !== prevA) live_flip++;
      prevA = {JA1, JA2};
      if (i == 0) begin
        pA = {JA1, JA2};
        pB = {JA3, JA4};
      end else if (i < 15) begin
        if ({JA1, JA2} !== pA) stA = 1'b0;
        if ({JA3, JA4} !== pB) stB = 1'b0;
      end
      if (i == 8) begin
        bA = busy_a;
        bB = busy_b;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({enableA, enableB, JA1, JA2, JA3, JA4, busy_a, busy_b} !== 8'h00)
      $display("FAIL reset_hold: outputs %b, expected 00000000",
               {enableA, enableB, JA1, JA2, JA3, JA4, busy_a, busy_b});
    else passes++;
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      measure();
      checks++;
      if ({hA, hB} !== {32'd0, 32'd0} || pA !== 2'b00 || pB !== 2'b00 || {bA, bB} !== 2'b00)
        $display("FAIL reset_idle p%0d: enA %0d enB %0d pinsA %b pinsB %b busy %b%b, expected all 0",
                 j, hA, hB, pA, pB, bA, bB);
      else passes++;
    end
  endtask

  task automatic test_ramp_a();
    logic bclean = 1'b1;
    align();
    speed_a = 3'd3; dir_a = 1'b1;
    for (int j = 0; j < 8; j++) begin
      measure();
      if (hB != 0 || pB !== 2'b00) bclean = 1'b0;
      checks++;
      if (hA !== ramp_hi[j]) $display("FAIL ramp_duty p%0d: enableA high %0d, expected %0d", j, hA, ramp_hi[j]);
      else passes++;
      checks++;
      if (pA !== ramp_pins[j]) $display("FAIL ramp_pins p%0d: JA1/JA2 %b, expected %b", j, pA, ramp_pins[j]);
      else passes++;
      checks++;
      if (bA !== ramp_busy[j]) $display("FAIL ramp_busy p%0d: busy_a %b, expected %b", j, bA, ramp_busy[j]);
      else passes++;
    end
    checks++;
    if (bclean !== 1'b1) $display("FAIL ramp_chan_b: channel B disturbed (%b), expected untouched (1)", bclean);
    else passes++;
  endtask

  task automatic test_reversal();
    logic stable = 1'b1;
    live_flip = 0;
    prevA = {JA1, JA2};
    dir_a = 1'b0;
    for (int j = 0; j < 17; j++) begin
      measure();
      if (!stA) stable = 1'b0;
      checks++;
      if (hA !== rev_hi[j]) $display("FAIL rev_duty p%0d: enableA high %0d, expected %0d", j, hA, rev_hi[j]);
      else passes++;
      checks++;
      if (pA !== rev_pins[j]) $display("FAIL rev_pins p%0d: JA1/JA2 %b, expected %b", j, pA, rev_pins[j]);
      else passes++;
      checks++;
      if (bA !== rev_busy[j]) $display("FAIL rev_busy p%0d: busy_a %b, expected %b", j, bA, rev_busy[j]);
      else passes++;
    end
    checks++;
    if (live_flip !== 0) $display("FAIL rev_live_flip: %0d pin changes with enable high, expected 0", live_flip);
    else passes++;
    checks++;
    if (stable !== 1'b1) $display("FAIL rev_pin_stable: mid-period pin change seen (%b), expected 1", stable);
    else passes++;
  endtask

  task automatic test_full_speed();
    logic bclean = 1'b1;
    speed_a = 3'd0;
    repeat (10) measure();
    measure();
    checks++;
    if (hA !== 0 || pA !== 2'b00 || bA !== 1'b0)
      $display("FAIL stop_idle: enableA %0d pins %b busy %b, expected 0 00 0", hA, pA, bA);
    else passes++;
    speed_a = 3'd7; dir_a = 1'b1;
    for (int j = 0; j < 17; j++) begin
      measure();
      if (hB != 0 || pB !== 2'b00) bclean = 1'b0;
      checks++;
      if (hA !== full_hi[j]) $display("FAIL full_duty p%0d: enableA high %0d, expected %0d", j, hA, full_hi[j]);
      else passes++;
    end
    checks++;
    if (pA !== 2'b10) $display("FAIL full_pins: JA1/JA2 %b, expected 10", pA);
    else passes++;
    checks++;
    if (bclean !== 1'b1) $display("FAIL full_chan_b: channel B disturbed (%b), expected untouched (1)", bclean);
    else passes++;
  endtask

  task automatic test_brake_b();
    speed_b = 3'd6; dir_b = 1'b1;
    for (int j = 0; j < 10; j++) measure();
    checks++;
    if (hB !== 8) $display("FAIL brake_pre_level: enableB high %0d, expected 8", hB);
    else passes++;
    brake_b = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({JA3, JA4} !== 2'b10) $display("FAIL brake_early: JA3/JA4 %b after 2 cycles, expected 10", {JA3, JA4});
    else passes++;
    @(negedge clock);
    checks++;
    if ({JA3, JA4, enableB} !== 3'b111) $display("FAIL brake_entry: JA3/JA4/enableB %b, expected 111", {JA3, JA4, enableB});
    else passes++;
    checks++;
    if ({JA1, JA2, enableA} !== 3'b101) $display("FAIL brake_chan_a: JA1/JA2/enableA %b, expected 101", {JA1, JA2, enableA});
    else passes++;
    align();
    for (int j = 0; j < 6; j++) begin
      measure();
      if (j == 0) brake_b = 1'b0;
      checks++;
      if (hB !== brk_hi[j]) $display("FAIL brake_duty p%0d: enableB high %0d, expected %0d", j, hB, brk_hi[j]);
      else passes++;
      checks++;
      if (pB !== brk_pins[j]) $display("FAIL brake_pins p%0d: JA3/JA4 %b, expected %b", j, pB, brk_pins[j]);
      else passes++;
    end
  endtask

  task automatic test_reset_in_dead();
    dir_a = 1'b0;
    for (int j = 0; j < 16; j++) begin
      measure();
      if (j == 14) begin
        checks++;
        if (hA !== 2 || pA !== 2'b10) $display("FAIL dead_pre: enableA %0d pins %b, expected 2 10", hA, pA);
        else passes++;
      end
    end
    checks++;
    if (hA !== 0 || pA !== 2'b00 || bA !== 1'b1)
      $display("FAIL dead_enter: enableA %0d pins %b busy %b, expected 0 00 1", hA, pA, bA);
    else passes++;
    repeat (5) @(negedge clock);
    checks++;
    if ({JA3, JA4} !== 2'b10) $display("FAIL dead_chan_b_live: JA3/JA4 %b, expected 10", {JA3, JA4});
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if ({enableA, enableB, JA1, JA2, JA3, JA4, busy_a, busy_b} !== 8'h00)
      $display("FAIL async_reset: outputs %b, expected 00000000",
               {enableA, enableB, JA1, JA2, JA3, JA4, busy_a, busy_b});
    else passes++;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int j = 0; j < 6; j++) begin
      measure();
      checks++;
      if (hA !== rst_hi[j] || pA !== rstA_pins[j])
        $display("FAIL post_reset_a p%0d: enableA %0d pins %b, expected %0d %b", j, hA, pA, rst_hi[j], rstA_pins[j]);
      else passes++;
      checks++;
      if (hB !== rst_hi[j] || pB !== rstB_pins[j])
        $display("FAIL post_reset_b p%0d: enableB %0d pins %b, expected %0d %b", j, hB, pB, rst_hi[j], rstB_pins[j]);
      else passes++;
    end
  endtask

  initial begin
    prevA = 2'b00;
    live_flip = 0;
    test_reset();
    test_ramp_a();
    test_reversal();
    test_full_speed();
    test_brake_b();
    test_reset_in_dead();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
